// File: rtl/eth_rx_pkt_buf.sv
// Receive byte buffer: commits good frames (FCS stripped) and streams them out; ~3 cycles commit-to-first-beat,
// M_T* holds while M_Tready is low. Optional Good_Cnt/Drop_Cnt outputs under ETH_RX_BUF_STATS_EN.
module eth_rx_pkt_buf #(
    parameter int pDEPTH_LOG2 = 11,
    parameter int pFRM_DEPTH  = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Byte_Rdy,
    input  logic [7:0]  Byte,
    input  logic        Pld_Valid,
    input  logic        Frame_End,
    input  logic        Frame_Ok,
    input  logic        Frame_Abort,
    output logic [7:0]  M_Tdata,
    output logic        M_Tvalid,
    output logic        M_Tlast,
    input  logic        M_Tready
`ifdef ETH_RX_BUF_STATS_EN
    ,
    output logic [15:0] Good_Cnt,
    output logic [15:0] Drop_Cnt
`endif
);

    localparam int AW    = pDEPTH_LOG2;
    localparam int PW    = pDEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << pDEPTH_LOG2;
    localparam int IW    = (pFRM_DEPTH > 1) ? $clog2(pFRM_DEPTH) : 1;
    localparam int CW    = $clog2(pFRM_DEPTH + 1);

    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]   frm_len_q, frm_len_d, rd_rem_q, rd_rem_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    rd_dat_q;
    rd_state_t     state_q, state_d;

    logic [15:0]   flen_mem_q [pFRM_DEPTH];
    logic [IW-1:0] flen_wr_q, flen_wr_d, flen_rd_q, flen_rd_d;
    logic [CW-1:0] flen_cnt_q, flen_cnt_d;
    logic          flen_vld, flen_pop, flen_full;
    logic [15:0]   flen_dat;

    logic          byte_in, full, wr_en, ovf_now, commit, hs, rd_en;
    logic [PW-1:0] wr_ptr_eff;
    logic [15:0]   frm_len_eff;
    logic [AW-1:0] rd_addr;

    assign flen_vld = (flen_cnt_q != '0);
    assign flen_dat = flen_mem_q[flen_rd_q];

    // Write side: the byte accepted in a Frame_End cycle is included before the commit decision.
    always_comb begin
        byte_in     = Byte_Rdy && Pld_Valid;
        full        = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
        wr_en       = byte_in && !full;
        ovf_now     = ovf_q || (byte_in && full);
        wr_ptr_eff  = wr_ptr_q + PW'(wr_en);
        frm_len_eff = frm_len_q + 16'(wr_en);
        // The frame currently being streamed still holds one of the pFRM_DEPTH slots.
        flen_full   = (int'(flen_cnt_q) + int'(state_q != RD_IDLE)) >= pFRM_DEPTH;
        commit      = Frame_End && !Frame_Abort && Frame_Ok && !ovf_now &&
                      (frm_len_eff >= 16'd5) && !flen_full;

        wr_ptr_d  = wr_ptr_eff;
        cmt_ptr_d = cmt_ptr_q;
        frm_len_d = frm_len_eff;
        ovf_d     = ovf_now;
        if (Frame_End || Frame_Abort) begin
            frm_len_d = '0;
            ovf_d     = 1'b0;
            if (commit) begin
                cmt_ptr_d = wr_ptr_eff - PW'(4);
                wr_ptr_d  = wr_ptr_eff - PW'(4);
            end else begin
                wr_ptr_d  = cmt_ptr_q;
            end
        end
    end

    always_comb begin
        flen_wr_d = flen_wr_q;
        flen_rd_d = flen_rd_q;
        if (commit)
            flen_wr_d = (flen_wr_q == IW'(pFRM_DEPTH - 1)) ? '0 : flen_wr_q + 1'b1;
        if (flen_pop)
            flen_rd_d = (flen_rd_q == IW'(pFRM_DEPTH - 1)) ? '0 : flen_rd_q + 1'b1;
        flen_cnt_d = flen_cnt_q + CW'(commit) - CW'(flen_pop);
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            state_q <= RD_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:   if (flen_vld) state_d = RD_FETCH;
            RD_FETCH:  state_d = RD_STREAM;
            RD_STREAM: if (M_Tready && (rd_rem_q == 16'd1))
                           state_d = flen_vld ? RD_FETCH : RD_IDLE;
            default:   state_d = RD_IDLE;
        endcase
    end

    // Next byte is fetched on the handshake itself so back-to-back beats have no bubble.
    always_comb begin
        M_Tvalid = (state_q == RD_STREAM);
        M_Tlast  = M_Tvalid && (rd_rem_q == 16'd1);
        M_Tdata  = rd_dat_q;
        hs       = M_Tvalid && M_Tready;
        flen_pop = flen_vld && ((state_q == RD_IDLE) || (hs && M_Tlast));
        rd_ptr_d = rd_ptr_q + PW'(hs);
        rd_rem_d = flen_pop ? flen_dat : rd_rem_q - 16'(hs);
        rd_en    = (state_q == RD_FETCH) || (hs && !M_Tlast);
        rd_addr  = rd_ptr_d[AW-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            frm_len_q  <= '0;
            ovf_q      <= 1'b0;
            rd_rem_q   <= '0;
            rd_dat_q   <= '0;
            flen_wr_q  <= '0;
            flen_rd_q  <= '0;
            flen_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            frm_len_q  <= frm_len_d;
            ovf_q      <= ovf_d;
            rd_rem_q   <= rd_rem_d;
            flen_wr_q  <= flen_wr_d;
            flen_rd_q  <= flen_rd_d;
            flen_cnt_q <= flen_cnt_d;
            if (rd_en)
                rd_dat_q <= mem_q[rd_addr];
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en)
            mem_q[wr_ptr_q[AW-1:0]] <= Byte;
        if (commit)
            flen_mem_q[flen_wr_q] <= frm_len_eff - 16'd4;
    end

`ifdef ETH_RX_BUF_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d, drop_cnt_q, drop_cnt_d;
    logic        drop_evt;

    always_comb begin
        drop_evt   = (Frame_End && !Frame_Abort && !commit) ||
                     (Frame_Abort && (frm_len_eff != 16'd0));
        good_cnt_d = good_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (commit && (good_cnt_q != 16'hFFFF))
            good_cnt_d = good_cnt_q + 16'd1;
        if (drop_evt && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign Good_Cnt = good_cnt_q;
    assign Drop_Cnt = drop_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_eth_rx_pkt_buf.sv
// Directed + randomized bench for eth_rx_pkt_buf with a frame-level queue model of committed payload.
module tb_eth_rx_pkt_buf;

    localparam int LOG2  = 7;
    localparam int DEPTH = 1 << LOG2;
    localparam int FRMS  = 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Byte_Rdy = 1'b0;
    logic [7:0] Byte = 8'd0;
    logic       Pld_Valid = 1'b0;
    logic       Frame_End = 1'b0;
    logic       Frame_Ok = 1'b0;
    logic       Frame_Abort = 1'b0;
    logic       M_Tready = 1'b0;
    logic [7:0] M_Tdata;
    logic       M_Tvalid;
    logic       M_Tlast;

    always #5 Clk = ~Clk;

    eth_rx_pkt_buf #(.pDEPTH_LOG2(LOG2), .pFRM_DEPTH(FRMS)) dut (
        .Clk(Clk), .Rst(Rst),
        .Byte_Rdy(Byte_Rdy), .Byte(Byte), .Pld_Valid(Pld_Valid),
        .Frame_End(Frame_End), .Frame_Ok(Frame_Ok), .Frame_Abort(Frame_Abort),
        .M_Tdata(M_Tdata), .M_Tvalid(M_Tvalid), .M_Tlast(M_Tlast), .M_Tready(M_Tready)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];          // {last, byte} of every committed payload byte not yet consumed
    int         exp_frames = 0;
    int         done_frames = 0;
    int         beats = 0;
    int         beat_idx = 0;
    int         first_cyc = 0;
    int         last_span = 0;
    int         cyc = 0;
    int         rdy_mode = 0;      // 0 stall, 1 always ready, 2 random, 3 toggle
    logic       stall_prev = 1'b0;
    logic [9:0] prev_word = '0;
    logic [8:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    always @(posedge Clk) cyc++;

    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0:       M_Tready = 1'b0;
            1:       M_Tready = 1'b1;
            2:       M_Tready = 1'($urandom_range(0, 1));
            default: M_Tready = ~M_Tready;
        endcase
    end

    // Output monitor: every accepted beat is matched against the model, stalls must hold.
    always @(negedge Clk) begin
        if (Rst) begin
            stall_prev = 1'b0;
            beat_idx   = 0;
        end else begin
            if (stall_prev)
                chk("hold_stable", {22'd0, M_Tvalid, M_Tlast, M_Tdata}, {22'd0, prev_word});
            if (M_Tvalid && M_Tready) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("tdata", M_Tdata, mon_e[7:0]);
                    chk("tlast", M_Tlast, mon_e[8]);
                    if (beat_idx == 0) first_cyc = cyc;
                    beat_idx++;
                    beats++;
                    if (mon_e[8]) begin
                        last_span = cyc - first_cyc;
                        beat_idx  = 0;
                        done_frames++;
                    end
                end
            end
            stall_prev = M_Tvalid && !M_Tready;
            prev_word  = {M_Tvalid, M_Tlast, M_Tdata};
        end
    end

    task automatic push_exp(input logic [7:0] fb[$], input int n);
        for (int i = 0; i < n - 4; i++)
            exp_q.push_back({(i == n - 5), fb[i]});
        exp_frames++;
    endtask

    // term: 0 separate Frame_End, 1 Frame_End with last byte, 2 Frame_Abort, 3 abort+end, 4 none
    task automatic send_frame(input int n, input bit ok, input int term, input bit gaps,
                              input bit exp_commit);
        logic [7:0] fb[$];
        int g;
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    Byte_Rdy  = 1'($urandom_range(0, 1));
                    Pld_Valid = 1'b0;
                    Byte      = 8'($urandom);
                    tick();
                end
            end
            Byte_Rdy  = 1'b1;
            Pld_Valid = 1'b1;
            Byte      = fb[i];
            if (i == n - 1 && term == 1) begin
                Frame_End = 1'b1;
                Frame_Ok  = ok;
                if (exp_commit) push_exp(fb, n);
            end
            tick();
            Byte_Rdy  = 1'b0;
            Pld_Valid = 1'b0;
            Frame_End = 1'b0;
            Frame_Ok  = 1'b0;
        end
        if (term == 0 || term == 2 || term == 3 || (term == 1 && n == 0)) begin
            Frame_End   = (term != 2);
            Frame_Abort = (term >= 2);
            Frame_Ok    = ok;
            if (exp_commit) push_exp(fb, n);
            tick();
            Frame_End   = 1'b0;
            Frame_Abort = 1'b0;
            Frame_Ok    = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            tick();
            c++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        repeat (3) tick();
        chk({tag, "_idle"}, M_Tvalid, 0);
        chk({tag, "_frames"}, done_frames, exp_frames);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c, b0, n, term, r;
        bit  ok, gp, cm;

        Rst = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", M_Tvalid, 0);
        chk("rst_tlast", M_Tlast, 0);
        chk("rst_tdata", M_Tdata, 0);
        Rst = 1'b0;
        tick();

        // 64-byte payload, always ready: exact data, last on byte 64, no gaps
        rdy_mode = 1;
        send_frame(68, 1'b1, 0, 1'b0, 1'b1);
        wait_drain("good64");
        chk("no_gap_span", last_span, 63);
        send_frame(68, 1'b1, 1, 1'b0, 1'b1);
        wait_drain("good64_end_with_byte");

        // Bad CRC dropped, following good frame delivered
        send_frame(68, 1'b0, 0, 1'b0, 1'b0);
        send_frame(14, 1'b1, 0, 1'b0, 1'b1);
        wait_drain("crc_bad");

        // Abort after 12 bytes, abort+end together, then good 20-byte frame
        send_frame(12, 1'b1, 2, 1'b0, 1'b0);
        send_frame(20, 1'b1, 3, 1'b0, 1'b0);
        send_frame(24, 1'b1, 0, 1'b0, 1'b1);
        wait_drain("abort");

        // Length boundaries: 0 and 4 bytes dropped, 5 bytes gives 1-byte payload
        send_frame(0, 1'b1, 0, 1'b0, 1'b0);
        send_frame(4, 1'b1, 0, 1'b0, 1'b0);
        send_frame(5, 1'b1, 1, 1'b0, 1'b1);
        wait_drain("min_len");

        // Overflow with reader stalled; then an exactly-full frame; then overflow against it
        rdy_mode = 0;
        tick();
        send_frame(144, 1'b1, 0, 1'b0, 1'b0);
        repeat (5) tick();
        chk("ovf_no_valid", M_Tvalid, 0);
        send_frame(DEPTH, 1'b1, 0, 1'b0, 1'b1);
        repeat (5) tick();
        chk("full_frame_valid", M_Tvalid, 1);
        send_frame(14, 1'b1, 0, 1'b0, 1'b0);
        rdy_mode = 1;
        wait_drain("ovf");
        send_frame(34, 1'b1, 0, 1'b1, 1'b1);
        wait_drain("after_ovf");

        // Frame-count limit: fifth frame dropped, released with toggling ready
        rdy_mode = 0;
        tick();
        for (int i = 0; i < 4; i++) send_frame(12, 1'b1, 0, 1'b0, 1'b1);
        send_frame(12, 1'b1, 0, 1'b0, 1'b0);
        repeat (4) tick();
        rdy_mode = 3;
        wait_drain("frm_limit");

        // Reset mid-stream
        rdy_mode = 1;
        b0 = beats;
        send_frame(44, 1'b1, 0, 1'b0, 1'b1);
        c = 0;
        while (beats < b0 + 15 && c < 300) begin
            tick();
            c++;
        end
        chk("mid_stream_reached", beats >= b0 + 15, 1);
        Rst = 1'b1;
        exp_q.delete();
        exp_frames = done_frames;
        tick();
        chk("rst_mid_tvalid", M_Tvalid, 0);
        chk("rst_mid_tlast", M_Tlast, 0);
        chk("rst_mid_tdata", M_Tdata, 0);
        Rst = 1'b0;
        tick();
        send_frame(10, 1'b1, 4, 1'b0, 1'b0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        tick();
        send_frame(20, 1'b1, 0, 1'b0, 1'b1);
        send_frame(44, 1'b1, 1, 1'b1, 1'b1);
        wait_drain("post_reset");

        // Randomized traffic, admitted only when neither buffer space nor frame slots can run out
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            n  = $urandom_range(0, 40);
            r  = $urandom_range(0, 9);
            term = (r == 0) ? 2 : (r == 1) ? 3 : (r % 2);
            ok = ($urandom_range(0, 4) != 0);
            gp = 1'($urandom_range(0, 1));
            cm = ok && (term <= 1) && (n >= 5);
            c = 0;
            while ((exp_q.size() + n > DEPTH || exp_frames - done_frames > FRMS - 1) && c < 3000) begin
                tick();
                c++;
            end
            chk("admit_wait", c < 3000, 1);
            send_frame(n, ok, term, gp, cm);
        end
        wait_drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eth_rx_pkt_buf.md
ETH_RX_PKT_BUF -- requirements
Module: eth_rx_pkt_buf

Interface
REQ-001 SHALL have parameter pDEPTH_LOG2, default 11, byte-buffer depth = 2**pDEPTH_LOG2.
REQ-002 SHALL have parameter pFRM_DEPTH, default 4, max committed frames awaiting readout.
REQ-003 Clk  input  1  clock; single domain, RMII reference clock.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Byte_Rdy  input  1  one-cycle strobe, Byte valid.
REQ-006 Byte  input  8  received byte.
REQ-007 Pld_Valid  input  1  high while receive control is in payload/FCS phase; qualifies Byte_Rdy.
REQ-008 Frame_End  input  1  one-cycle pulse, frame finished.
REQ-009 Frame_Ok  input  1  CRC result, sampled only with Frame_End.
REQ-010 Frame_Abort  input  1  one-cycle pulse, discard current frame (e.g. EtherType invalid, carrier loss).
REQ-011 M_Tdata  output  8  streamed payload byte.
REQ-012 M_Tvalid  output  1  M_Tdata valid.
REQ-013 M_Tlast  output  1  last payload byte of frame.
REQ-014 M_Tready  input  1  downstream accept.

Function
REQ-015 SHALL write Byte at tentative pointer Wr_Ptr when Byte_Rdy & Pld_Valid & not full; Wr_Ptr increments; frame byte count Frm_Len (16-bit) increments.
REQ-016 Pointers SHALL be pDEPTH_LOG2+1 bits, wrap modulo 2**(pDEPTH_LOG2+1); full = (Wr_Ptr - Rd_Ptr) == 2**pDEPTH_LOG2.
REQ-017 Byte_Rdy & Pld_Valid while full SHALL not write and SHALL set sticky Ovf flag for current frame.
REQ-018 Byte written in the same cycle as Frame_End SHALL be counted before commit evaluation.
REQ-019 On Frame_End SHALL commit iff Frame_Ok & ~Ovf & Frm_Len >= 5 & frame-length FIFO not full.
REQ-020 Commit SHALL push Frm_Len-4 (FCS stripped) into frame-length FIFO and set Cmt_Ptr <= Wr_Ptr-4; FCS bytes become free space.
REQ-021 Non-commit Frame_End SHALL roll back Wr_Ptr <= Cmt_Ptr.
REQ-022 Frame_Abort SHALL roll back Wr_Ptr <= Cmt_Ptr; Frame_Abort and Frame_End same cycle: abort wins, nothing committed.
REQ-023 Frm_Len and Ovf SHALL clear on every Frame_End or Frame_Abort.
REQ-024 Committed data SHALL never be overwritten or rolled back.
REQ-025 Read FSM states: RD_IDLE, RD_FETCH, RD_STREAM.
REQ-026 RD_IDLE -> RD_FETCH when frame-length FIFO non-empty; pops length into Rd_Rem.
REQ-027 RD_FETCH SHALL issue synchronous RAM read at Rd_Ptr, then -> RD_STREAM with M_Tvalid=1 next cycle.
REQ-028 In RD_STREAM M_Tvalid, M_Tdata, M_Tlast SHALL hold stable until M_Tready; each handshake advances Rd_Ptr, decrements Rd_Rem, loads next byte with no bubble.
REQ-029 M_Tlast SHALL be 1 exactly when Rd_Rem == 1.
REQ-030 Handshake with M_Tlast -> RD_IDLE; M_Tvalid deasserts unless next frame already pending (then RD_FETCH).
REQ-031 Read side SHALL only read addresses below Cmt_Ptr.
REQ-032 Simultaneous write and read SHALL be supported every cycle; full evaluated from pointers at cycle start.

Reset
REQ-033 Rst SHALL set Wr_Ptr, Cmt_Ptr, Rd_Ptr, Frm_Len, Ovf, Rd_Rem to 0, empty frame-length FIFO, read FSM RD_IDLE.
REQ-034 Rst SHALL force M_Tvalid=0, M_Tlast=0, M_Tdata=0.
REQ-035 Rst mid-frame or mid-stream SHALL discard all buffered and partial frames; RAM contents need not clear.

Configuration
REQ-036 With ETH_RX_BUF_STATS_EN defined SHALL add outputs Good_Cnt[15:0], Drop_Cnt[15:0], reset 0, saturating at 16'hFFFF.
REQ-037 Good_Cnt SHALL increment per commit; Drop_Cnt per non-commit Frame_End or per Frame_Abort of a frame with Frm_Len > 0.
REQ-038 Without ETH_RX_BUF_STATS_EN ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-039 64-byte payload + 4 FCS, Frame_Ok=1, M_Tready=1 -> 64 bytes out, bytes match, M_Tlast on byte 64, no gaps.
REQ-040 Same frame with Frame_Ok=0, then good 10+4 frame -> only 10-byte frame emitted; Good_Cnt=1, Drop_Cnt=1.
REQ-041 Frame_Abort after 12 bytes, then good 20+4 frame -> 20-byte frame output; no abort bytes leak.
REQ-042 pDEPTH_LOG2=6, M_Tready=0, 70-byte frame -> Ovf, dropped, buffer empty; next 30+4 frame delivered intact.
REQ-043 Five good 8+4 frames, M_Tready=0, pFRM_DEPTH=4 -> fifth dropped; release M_Tready toggling 1/0 -> four frames, stable data while stalled.
REQ-044 Rst asserted mid-stream of 40-byte frame -> M_Tvalid=0 next cycle; later frames stream from address 0 correctly.
